// File: rtl/seq_divider_if.sv
// Request/response bundle for the sequential divider.
// master: the issue side that sends operands and takes results.
// slave:  the divider itself.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output in_valid, op, dividend, divisor, flush, out_ready,
        input  in_ready, out_valid, result, div_by_zero
    );

    modport slave (
        input  in_valid, op, dividend, divisor, flush, out_ready,
        output in_ready, out_valid, result, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// op: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Signed ops divide magnitudes and
// restore the signs in FIX. Divide-by-zero and signed overflow skip the
// iteration and go straight to FIX, so their result appears one cycle
// after accept instead of WIDTH+1.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             div_zero, sgn_ovf;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] q_fix, r_fix;

    // Operand decode, the restoring step datapath and sign restoration.
    assign accept   = bus.in_valid && bus.in_ready;
    assign a_neg    = !bus.op[0] && bus.dividend[WIDTH-1];
    assign b_neg    = !bus.op[0] && bus.divisor[WIDTH-1];
    assign a_abs    = a_neg ? -bus.dividend : bus.dividend;
    assign b_abs    = b_neg ? -bus.divisor  : bus.divisor;
    assign div_zero = (bus.divisor == '0);
    assign sgn_ovf  = !bus.op[0] && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                      && (bus.divisor == '1);
    // One extra bit so divisors >= 2^(WIDTH-1) compare correctly.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvsr_q};
    assign take     = (shifted >= {1'b0, dvsr_q});
    assign q_fix    = qneg_q ? -quo_q : quo_q;
    assign r_fix    = rneg_q ? -rem_q : rem_q;

    assign bus.in_ready    = (state_q == IDLE) && !bus.flush;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

    // Next-state and datapath: accept, iterate, fix signs, hold until taken.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = bus.op;
                    cnt_d  = CNT_W'(WIDTH);
                    dbz_d  = div_zero;
                    dvsr_d = b_abs;
                    if (div_zero) begin
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = FIX;
                    end else if (sgn_ovf) begin
                        quo_d   = bus.dividend;
                        rem_d   = '0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = FIX;
                    end else begin
                        quo_d   = a_abs;
                        rem_d   = '0;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], take};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = op_q[1] ? r_fix : q_fix;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything; result keeps its last value.
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=32): stimulus pushes expected
// results, a monitor pops and compares whenever out_valid rises.
module tb_seq_divider;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           acc;
        int           lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];
    exp_t cur;
    logic prev_ov;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop on each rising out_valid, then check the output is held.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", W'(bus.out_valid), W'(0));
                end else begin
                    cur = sb.pop_front();
                    check("result", bus.result, cur.res);
                    check("div_by_zero", W'(bus.div_by_zero), W'(cur.dbz));
                    check("latency", W'(cyc - cur.acc), W'(cur.lat));
                end
            end else if (bus.out_valid && prev_ov) begin
                check("hold_result", bus.result, cur.res);
                check("hold_in_ready", W'(bus.in_ready), W'(0));
            end
            prev_ov = bus.out_valid;
        end
    end

    // Issue one request; busy returns how many cycles in_ready was low first.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ed, input int lat,
                        input bit expect_out, output int busy);
        exp_t e;
        busy = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        while (!bus.in_ready && busy < 200) begin
            @(negedge clk);
            busy++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", W'(bus.in_ready), W'(1));
        end else if (expect_out) begin
            e.res = er;
            e.dbz = ed;
            e.acc = cyc + 1;
            e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        // Garbage after accept: the divider must have latched everything.
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = '0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
        check("out_valid_timeout", W'(bus.out_valid), W'(1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (sb.size() != 0 || bus.out_valid); i++) @(negedge clk);
        check("drain_timeout", W'(sb.size() != 0 || bus.out_valid), W'(0));
    endtask

    // Directed stimulus: {op, dividend, divisor, expected result, dbz, latency}.
    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[10];
    int   busy;

    initial begin
        vecs[0] = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 33};
        vecs[1] = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0, 33};
        vecs[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 33};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 33};
        vecs[4] = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          1'b0, 33};
        vecs[5] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  1'b0, 33};
        vecs[6] = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1};
        vecs[7] = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1, 1};
        vecs[8] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1};
        vecs[9] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1};

        cyc = 0; n_cmp = 0; n_err = 0; prev_ov = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.op = 2'b00; bus.dividend = '0; bus.divisor = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_out_valid", W'(bus.out_valid), W'(0));
        check("reset_in_ready", W'(bus.in_ready), W'(1));
        check("reset_result", bus.result, W'(0));
        check("reset_dbz", W'(bus.div_by_zero), W'(0));
        rst_n = 1'b1;

        // Main function and special cases.
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].dbz, vecs[i].lat, 1'b1, busy);
        end
        wait_idle();

        // Backpressure: result held for 5 cycles, then handshake.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(2'b01, 32'd1000, 32'd10, 32'd100, 1'b0, 33, 1'b1, busy);
        wait_out();
        repeat (5) begin
            @(negedge clk);
            check("bp_result", bus.result, 32'd100);
            check("bp_in_ready", W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_valid_after", W'(bus.out_valid), W'(0));
        check("bp_in_ready_after", W'(bus.in_ready), W'(1));

        // Back-to-back: 34 busy cycles between accepts.
        send(2'b01, 32'd50, 32'd5, 32'd10, 1'b0, 33, 1'b1, busy);
        send(2'b11, 32'd50, 32'd7, 32'd1, 1'b0, 33, 1'b1, busy);
        check("b2b_busy_cycles", W'(busy), W'(34));
        wait_idle();

        // Flush 10 cycles into CALC: nothing must come out.
        send(2'b01, 32'd1000, 32'd3, 32'd0, 1'b0, 0, 1'b0, busy);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_in_ready", W'(bus.in_ready), W'(0));
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_calc_out_valid", W'(bus.out_valid), W'(0));
        check("flush_calc_in_ready", W'(bus.in_ready), W'(1));
        repeat (40) @(negedge clk);

        // Flush during DONE: out_valid drops, result keeps its value.
        bus.out_ready = 1'b0;
        send(2'b01, 32'd20, 32'd4, 32'd5, 1'b0, 33, 1'b1, busy);
        wait_out();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_done_out_valid", W'(bus.out_valid), W'(0));
        check("flush_done_result", bus.result, 32'd5);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        send(2'b01, 32'd81, 32'd9, 32'd9, 1'b0, 33, 1'b1, busy);
        wait_idle();

        // Asynchronous reset mid-CALC.
        send(2'b10, 32'd100, 32'd3, 32'd0, 1'b0, 0, 1'b0, busy);
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", W'(bus.out_valid), W'(0));
        check("arst_in_ready", W'(bus.in_ready), W'(1));
        check("arst_result", bus.result, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b10, 32'd17, 32'hFFFF_FFFB, 32'd2, 1'b0, 33, 1'b1, busy);
        wait_idle();

        check("scoreboard_empty", W'(sb.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
